// File: rtl/rng_pkg.sv
// rng_pkg: shared state type, tap masks and default seed for the LFSR random generator
package rng_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, VALID} state_t;
  localparam logic [7:0] RNG_TAPS8 = 8'hB8;
  localparam logic [15:0] RNG_TAPS16 = 16'hB400;
  localparam logic [31:0] RNG_TAPS32 = 32'h8020_0003;
  localparam logic [15:0] RNG_DEFAULT_SEED = 16'hACE1;
endpackage

// File: rtl/lfsr_galois_step.sv
// lfsr_galois_step: one right-shifting Galois LFSR step and the bit it shifts out
module lfsr_galois_step #(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = 16'hB400
) (
  input  logic [LFSR_W-1:0] s,
  output logic [LFSR_W-1:0] s_next,
  output logic              b
);
  assign b = s[0];
  assign s_next = (s >> 1) ^ (s[0] ? TAPS : '0);
endmodule

// File: rtl/rng_lfsr_gen.sv
// rng_lfsr_gen: LFSR random value generator with valid/ready output.
// RNG_RANGE_LIMIT_EN adds a CHECK state that rejects values >= RANGE_MAX.
module rng_lfsr_gen #(
  parameter int LFSR_W = 16,
  parameter int OUT_W = 3,
  parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(rng_pkg::RNG_TAPS16),
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(rng_pkg::RNG_DEFAULT_SEED),
  parameter int RANGE_MAX = 2**OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              free_run,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [OUT_W-1:0]  rnd_out,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy
);
  import rng_pkg::*;
  localparam int CW = $clog2(OUT_W + 1);
  state_t state, state_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n, s_next;
  logic [OUT_W-1:0] acc, acc_n, acc_sh, out_n;
  logic [CW-1:0] cnt, cnt_n;
  logic b, valid_n;
  lfsr_galois_step #(.LFSR_W(LFSR_W), .TAPS(TAPS)) u_step (.s(lfsr), .s_next(s_next), .b(b));
  assign acc_sh = OUT_W'({acc, b});
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    lfsr_n = lfsr;
    acc_n = acc;
    cnt_n = cnt;
    out_n = rnd_out;
    valid_n = rnd_valid;
    if (seed_load) begin
      lfsr_n = (seed_in == '0) ? DEFAULT_SEED : seed_in;
      state_n = IDLE;
      valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lfsr_n = free_run ? s_next : lfsr;
          if (req) begin
            state_n = SHIFT;
            acc_n = '0;
            cnt_n = '0;
          end
        end
        SHIFT: begin
          lfsr_n = s_next;
          acc_n = acc_sh;
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(OUT_W - 1)) begin
`ifdef RNG_RANGE_LIMIT_EN
            state_n = CHECK;
`else
            out_n = acc_sh;
            valid_n = 1'b1;
            state_n = VALID;
`endif
          end
        end
`ifdef RNG_RANGE_LIMIT_EN
        CHECK: begin
          // rejected candidates redraw from the already-advanced LFSR
          if ({1'b0, acc} >= (OUT_W + 1)'(RANGE_MAX)) begin
            state_n = SHIFT;
            acc_n = '0;
            cnt_n = '0;
          end else begin
            out_n = acc;
            valid_n = 1'b1;
            state_n = VALID;
          end
        end
`endif
        VALID: begin
          valid_n = rnd_ready ? 1'b0 : rnd_valid;
          state_n = rnd_ready ? IDLE : VALID;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lfsr <= DEFAULT_SEED;
      acc <= '0;
      cnt <= '0;
      rnd_out <= '0;
      rnd_valid <= 1'b0;
    end else begin
      state <= state_n;
      lfsr <= lfsr_n;
      acc <= acc_n;
      cnt <= cnt_n;
      rnd_out <= out_n;
      rnd_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_rng_lfsr_gen.sv
// tb_rng_lfsr_gen: table-driven scoreboard bench for rng_lfsr_gen with default parameters
module tb_rng_lfsr_gen;
  localparam int OUT_W = 3;
`ifdef RNG_RANGE_LIMIT_EN
  localparam int LAT = OUT_W + 1;
`else
  localparam int LAT = OUT_W;
`endif
  logic clk = 0, rst = 0, req = 0, free_run = 0, seed_load = 0, rnd_ready = 0;
  logic [15:0] seed_in = '0;
  logic [OUT_W-1:0] rnd_out;
  logic rnd_valid, busy;
  int tests = 0, fails = 0;
  logic [15:0] m;
  logic [OUT_W-1:0] q[$];
  typedef struct {
    logic load;
    logic [15:0] seed;
    int fr;
    int dly;
  } vec_t;
  vec_t vec[7];

  rng_lfsr_gen dut (
    .clk(clk), .rst(rst), .req(req), .free_run(free_run), .seed_load(seed_load),
    .seed_in(seed_in), .rnd_out(rnd_out), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic draw(input int fr, input int dly);
    logic [OUT_W-1:0] e, held;
    int n;
    free_run = 1;
    for (int i = 0; i < fr; i++) begin
      tick;
      m = step(m);
    end
    free_run = 0;
    e = '0;
    for (int i = 0; i < OUT_W; i++) begin
      e = {e[OUT_W-2:0], m[0]};
      m = step(m);
    end
    q.push_back(e);
    req = 1;
    tick;
    req = 0;
    chk("busy_after_req", busy, 1);
    n = 0;
    while (!rnd_valid && n < 20) begin
      tick;
      n++;
    end
    chk("latency", n, LAT);
    chk("busy_valid", busy, 1);
    chk("rnd_out", rnd_out, q.pop_front());
    held = rnd_out;
    for (int i = 0; i < dly; i++) begin
      req = ~req;
      tick;
      chk("hold", {rnd_valid, rnd_out}, {1'b1, held});
    end
    req = 0;
    rnd_ready = 1;
    tick;
    rnd_ready = 0;
    chk("valid_cleared", rnd_valid, 0);
    chk("busy_cleared", busy, 0);
    tick;
    chk("single_handshake", {busy, rnd_valid}, 2'b00);
    chk("lfsr_state", dut.lfsr, m);
  endtask

  initial begin
    vec[0] = '{1'b0, 16'h0000, 0, 0};
    vec[1] = '{1'b0, 16'h0000, 2, 0};
    vec[2] = '{1'b0, 16'h0000, 0, 10};
    vec[3] = '{1'b1, 16'h1234, 0, 2};
    vec[4] = '{1'b1, 16'h0000, 3, 1};
    vec[5] = '{1'b1, 16'hFFFF, 1, 0};
    vec[6] = '{1'b0, 16'h0000, 7, 3};
    m = 16'hACE1;
    tick;
    tick;
    rst = 1;
    tick;
    chk("reset_outputs", {busy, rnd_valid, rnd_out}, '0);
    chk("reset_lfsr", dut.lfsr, 16'hACE1);
    for (int v = 0; v < 7; v++) begin
      if (vec[v].load) begin
        seed_in = vec[v].seed;
        seed_load = 1;
        tick;
        seed_load = 0;
        m = (vec[v].seed == 0) ? 16'hACE1 : vec[v].seed;
        chk("seed_loaded", dut.lfsr, m);
      end
      draw(vec[v].fr, vec[v].dly);
      if (v == 0) chk("first_value", rnd_out, 3'b100);
    end
    // zero seed loaded mid-draw aborts and substitutes the default seed
    req = 1;
    tick;
    req = 0;
    tick;
    seed_in = 16'h0000;
    seed_load = 1;
    tick;
    seed_load = 0;
    chk("abort_lfsr", dut.lfsr, 16'hACE1);
    chk("abort_idle", {busy, rnd_valid}, 2'b00);
    for (int i = 0; i < 5; i++) tick;
    chk("abort_no_value", rnd_valid, 0);
    m = 16'hACE1;
    draw(0, 0);
    // asynchronous reset mid-draw
    req = 1;
    tick;
    req = 0;
    tick;
    rst = 0;
    #1;
    chk("async_reset", {busy, rnd_valid, rnd_out}, '0);
    chk("async_reset_lfsr", dut.lfsr, 16'hACE1);
    tick;
    rst = 1;
    tick;
    m = 16'hACE1;
    draw(5, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
